// File: rtl/calc_pkg.sv
// Shared constants and types for the calculator display path.
package calc_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [3:0] DIG_MINUS = 4'hA;
  localparam logic [3:0] DIG_ERR   = 4'hE;
  localparam logic [3:0] DIG_BLANK = 4'hF;

  localparam int unsigned MAX_POS = 32'd999999;
  localparam int unsigned MAX_NEG = 32'd99999;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    FORMAT = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: add 3 when the digit is 5 or more so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3 (
  input  logic [3:0] i_nibble,
  output logic [3:0] o_nibble
);

  // Conditional +3 correction of a single BCD digit
  always_comb begin
    if (i_nibble >= 4'd5) begin
      o_nibble = i_nibble + 4'd3;
    end else begin
      o_nibble = i_nibble;
    end
  end

endmodule

// File: rtl/calc_result_bcd_display.sv
// Sequential binary-to-BCD formatter: range check, iterative double-dabble
// conversion, then leading-zero blanking, minus placement and error display.
module calc_result_bcd_display
  import calc_pkg::*;
#(
  parameter int NUM_DIGITS = calc_pkg::NUM_DIGITS,
  parameter int BIN_W      = 40,
  parameter int CONV_BITS  = 20
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic [BIN_W-1:0]          i_result,
  input  logic                      i_sign,
  input  logic                      i_err,
  output logic [4*NUM_DIGITS-1:0]   o_digits,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(CONV_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CONV_BITS - 1);
  localparam logic [BCD_W-1:0] DIGITS_RST = {{(NUM_DIGITS-1){DIG_BLANK}}, 4'h0};
  localparam logic [BCD_W-1:0] DIGITS_ERR = {{(NUM_DIGITS-1){DIG_BLANK}}, DIG_ERR};

  state_e                 state_q,  state_d;
  logic [CONV_BITS-1:0]   bin_q,    bin_d;
  logic [BCD_W-1:0]       bcd_q,    bcd_d;
  logic [CNT_W-1:0]       cnt_q,    cnt_d;
  logic                   sign_q,   sign_d;
  logic                   err_q,    err_d;
  logic [BCD_W-1:0]       digits_q, digits_d;
  logic                   busy_q,   busy_d;
  logic                   done_q,   done_d;

  logic                   range_err;
  logic [BCD_W-1:0]       bcd_adj;
  logic [NUM_DIGITS-1:0]  keep;
  logic                   seen;
  logic [BCD_W-1:0]       fmt_digits;

  // Reject anything the six-digit display cannot show, including high result
  // bits that would otherwise alias into the 20 converted bits.
  assign range_err = i_err
                   | (~i_sign & (i_result > BIN_W'(MAX_POS)))
                   | ( i_sign & (i_result > BIN_W'(MAX_NEG)));

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_nibble (bcd_q[4*g +: 4]),
      .o_nibble (bcd_adj[4*g +: 4])
    );
  end

  // Build the display pattern from the finished BCD value
  always_comb begin
    keep       = '0;
    seen       = 1'b0;
    fmt_digits = DIGITS_RST;
    if (err_q) begin
      fmt_digits = DIGITS_ERR;
    end else begin
      // keep[i] is set when digit i or any digit above it is nonzero
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
        seen    = seen | (bcd_q[4*i +: 4] != 4'h0);
        keep[i] = seen;
      end
      keep[0] = 1'b1;
      fmt_digits[3:0] = bcd_q[3:0];
      // The minus sign lands in the first blanked position above the MSD
      for (int i = 1; i < NUM_DIGITS; i++) begin
        if (keep[i]) begin
          fmt_digits[4*i +: 4] = bcd_q[4*i +: 4];
        end else if (sign_q && (bcd_q != '0) && keep[i-1]) begin
          fmt_digits[4*i +: 4] = DIG_MINUS;
        end else begin
          fmt_digits[4*i +: 4] = DIG_BLANK;
        end
      end
    end
  end

  // Next-state and datapath control for IDLE -> CONV -> FORMAT
  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    err_d    = err_q;
    digits_d = digits_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          sign_d = i_sign;
          busy_d = 1'b1;
          if (range_err) begin
            err_d   = 1'b1;
            state_d = FORMAT;
          end else begin
            err_d   = 1'b0;
            bin_d   = i_result[CONV_BITS-1:0];
            bcd_d   = '0;
            cnt_d   = '0;
            state_d = CONV;
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      CONV: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d          = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = FORMAT;
        end else begin
          state_d = CONV;
        end
      end
      FORMAT: begin
        digits_d = fmt_digits;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers with asynchronous reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      err_q    <= 1'b0;
      digits_q <= DIGITS_RST;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      err_q    <= err_d;
      digits_q <= digits_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign o_digits = digits_q;
  assign o_busy   = busy_q;
  assign o_done   = done_q;

endmodule

// File: tb/tb_calc_result_bcd_display.sv
// Directed bench for calc_result_bcd_display with hand-computed expectations.
module tb_calc_result_bcd_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [39:0] result;
  logic        sign;
  logic        err;
  logic [23:0] digits;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  calc_result_bcd_display dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_result (result),
    .i_sign   (sign),
    .i_err    (err),
    .o_digits (digits),
    .o_busy   (busy),
    .o_done   (done)
  );

  task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One conversion: accept at E0, count edges until o_done, check result.
  // poke_k >= 0 pulses i_start with another value so it is seen at E(poke_k+1).
  task automatic do_conv(input string tag, input logic [39:0] r, input logic s,
                         input logic e, input logic [23:0] exp_d,
                         input int exp_lat, input int poke_k);
    int   k;
    logic busy_ok;
    @(negedge clk);
    result = r; sign = s; err = e; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; result = ~r; sign = ~s; err = 1'b0;
    k = 0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && k < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (k == poke_k) begin
        start = 1'b1; result = 40'd777;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk({tag, "_lat"}, 24'(k), 24'(exp_lat));
    chk({tag, "_digits"}, digits, exp_d);
    chk({tag, "_busy_during"}, {23'd0, busy_ok}, 24'd1);
    chk({tag, "_busy_after"}, {23'd0, busy}, 24'd0);
    @(negedge clk);
    chk({tag, "_done_width"}, {23'd0, done}, 24'd0);
  endtask

  initial begin
    int nd;
    int done_cnt;
    int exp_k [3];
    exp_k = '{21, 43, 65};

    rst_n = 1'b0; start = 1'b0; result = 40'd0; sign = 1'b0; err = 1'b0;
    #12;
    chk("rst_digits", digits, 24'hFFFFF0);
    chk("rst_busy", {23'd0, busy}, 24'd0);
    chk("rst_done", {23'd0, done}, 24'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_conv("pos123456", 40'd123456,  1'b0, 1'b0, 24'h123456, 21, -1);
    do_conv("neg42",     40'd42,      1'b1, 1'b0, 24'hFFFA42, 21, -1);
    do_conv("negzero",   40'd0,       1'b1, 1'b0, 24'hFFFFF0, 21, -1);
    do_conv("max_pos",   40'd999999,  1'b0, 1'b0, 24'h999999, 21, -1);
    do_conv("over_pos",  40'd1000000, 1'b0, 1'b0, 24'hFFFFFE, 1,  -1);
    do_conv("max_neg",   40'd99999,   1'b1, 1'b0, 24'hA99999, 21, -1);
    do_conv("over_neg",  40'd100000,  1'b1, 1'b0, 24'hFFFFFE, 1,  -1);
    do_conv("interior0", 40'd100000,  1'b0, 1'b0, 24'h100000, 21, -1);
    do_conv("err_flag",  40'd5,       1'b0, 1'b1, 24'hFFFFFE, 1,  -1);
    do_conv("neg1020",   40'd1020,    1'b1, 1'b0, 24'hFA1020, 21, -1);
    do_conv("alias20",   40'h00_0010_0005, 1'b0, 1'b0, 24'hFFFFFE, 1, -1);
    do_conv("alias39",   40'h80_0000_0007, 1'b1, 1'b0, 24'hFFFFFE, 1, -1);
    do_conv("pos_zero",  40'd0,       1'b0, 1'b0, 24'hFFFFF0, 21, -1);
    do_conv("neg1",      40'd1,       1'b1, 1'b0, 24'hFFFFA1, 21, -1);
    do_conv("ign_start", 40'd123456,  1'b0, 1'b0, 24'h123456, 21, 4);

    // Reset asserted shortly after E10 of a conversion aborts it
    @(negedge clk);
    result = 40'd654321; sign = 1'b0; err = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {23'd0, busy}, 24'd0);
    chk("abort_digits", digits, 24'hFFFFF0);
    chk("abort_done", {23'd0, done}, 24'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    chk("abort_no_done", 24'(done_cnt), 24'd0);
    chk("abort_hold", digits, 24'hFFFFF0);

    // i_start held high: one conversion every 22 cycles
    @(negedge clk);
    result = 40'd7; sign = 1'b0; err = 1'b0; start = 1'b1;
    @(posedge clk);
    nd = 0;
    for (int k = 0; k <= 66; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (nd < 3) begin
          chk("b2b_edge", 24'(k), 24'(exp_k[nd]));
          chk("b2b_digits", digits, 24'hFFFFF7);
        end else begin
          chk("b2b_extra_done", 24'(nd), 24'd3);
        end
        nd++;
      end
    end
    start = 1'b0;
    chk("b2b_count", 24'(nd), 24'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
